sdram_fifo_arbiter: RTL and testbench
=====================================

# sdram_fifo_arbiter

Schedules SDRAM burst traffic between the camera write FIFO and the display read FIFO, sitting directly above the SDRAM controller's request/acknowledge interface. It decides which side gets the next burst and issues one write or read request with a fixed burst length. It generates the burst start addresses and manages two frame banks as a ping-pong pair, so the display always reads the most recently completed camera frame.

## Interface
Parameters:
- BURST_LEN, 9'd256, words per SDRAM burst, 1..256.
- FRAME_WORDS, 23'd307200, words per frame (640x480). Must be an integer multiple of BURST_LEN.

Ports:
- clk  in  1  system clock, same domain as the SDRAM controller
- rst_n  in  1  asynchronous, active-low reset
- sdram_init_done  in  1  controller initialisation complete
- wr_fifo_level  in  10  words currently held in the write FIFO
- rd_fifo_room  in  10  free word slots in the read FIFO
- wr_frame_sync  in  1  one-cycle pulse at camera frame start
- sdram_wr_ack  in  1  controller write acknowledge, high during the write data phase
- sdram_rd_ack  in  1  controller read acknowledge, high while read data is valid
- sdram_wr_req  out  1  write burst request
- sdram_rd_req  out  1  read burst request
- sdram_wr_burst  out  9  write burst length; constant BURST_LEN
- sdram_rd_burst  out  9  read burst length; constant BURST_LEN
- sdram_wr_addr  out  24  write start address {wr_bank, wr_offset[22:0]}
- sdram_rd_addr  out  24  read start address {rd_bank, rd_offset[22:0]}
- wr_frame_done  out  1  one-cycle pulse when a full frame has been written
- wr_bank  out  1  bank currently being written
- rd_bank  out  1  bank currently being read

## Operation
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY. Reset state is IDLE.
- Eligibility:
  - wr_ok = (wr_fifo_level >= BURST_LEN).
  - rd_ok = (rd_fifo_room >= BURST_LEN).
  - Both are evaluated only in IDLE, and only when sdram_init_done = 1.
- Arbitration is round-robin on the last_grant flag (reset value: read).
  - If both sides are eligible, the side not granted last wins.
  - If only one side is eligible, that side wins.
  - If neither is eligible, the FSM stays in IDLE.
- IDLE -> WR_REQ sets sdram_wr_req = 1. IDLE -> RD_REQ sets sdram_rd_req = 1.
- WR_REQ -> WR_BUSY on the first cycle sdram_wr_ack = 1; req drops in that same registered update. RD_REQ -> RD_BUSY behaves the same way with sdram_rd_ack.
  - This prevents the controller re-accepting a stale request when it returns to idle.
- WR_BUSY / RD_BUSY -> IDLE on the falling edge of the ack (registered ack = 1, current ack = 0). That cycle is "burst complete".
- Write burst complete:
  - wr_offset += BURST_LEN.
  - If the new offset equals FRAME_WORDS:
    - wr_offset <= 0
    - done_bank <= wr_bank
    - wr_bank toggles
    - wr_frame_done pulses for 1 cycle.
- wr_frame_sync:
  - In IDLE or WR_REQ: wr_offset <= 0 immediately. Bank is unchanged, no frame_done pulse; the partial frame is discarded.
  - In WR_BUSY: the sync is latched and applied at burst complete, taking precedence over the normal increment.
- Read burst complete:
  - rd_offset += BURST_LEN.
  - At FRAME_WORDS: rd_offset <= 0 and rd_bank <= done_bank.
  - The reader therefore repeats the last finished frame if no new frame has completed.
- Reset values:
  - all requests 0
  - offsets 0
  - wr_bank 0, rd_bank 1, done_bank 1
  - wr_frame_done 0
  - sdram_wr_burst and sdram_rd_burst always equal BURST_LEN.
- sdram_init_done low: the FSM stays in IDLE and no requests are issued.
- Reset mid-burst: all state clears asynchronously. Requests drop immediately.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Request latency: eligibility sampled in IDLE at edge N -> req high after edge N+1.
- Addresses are updated only on burst-complete or sync cycles. They are stable from req assertion until the next burst-complete.
- Minimum gap between bursts: 1 IDLE cycle after burst complete.
- Simultaneous wr_frame_sync and write burst complete in the same cycle: the sync wins and wr_offset = 0.
- Offset arithmetic is 23-bit unsigned. Wrap is by equality compare with FRAME_WORDS; no modulo.

## Test plan
- Reset with init_done = 0 and wr_fifo_level = 512 -> no request. Raise init_done -> sdram_wr_req high 2 cycles later, sdram_wr_addr = 0x000000.
- Both eligible continuously, last_grant reset to read -> grants alternate W, R, W, R. Each write and each read address advances by 256.
- Ack model asserts wr_ack 3 cycles after req for 256 cycles -> req drops on the first ack cycle. IDLE is entered the cycle after ack falls. No second request while ack is high.
- 1200 write bursts -> wr_frame_done pulses once, wr_bank 0 -> 1, wr_offset returns to 0. The next read wrap sets rd_bank = 0.
- wr_frame_sync during WR_BUSY at offset 0x200 -> after completion wr_offset = 0 and the bank is unchanged.
- Assert rst_n low in the middle of RD_BUSY -> outputs return to reset values the same cycle. Operation resumes from offset 0.

Source files
------------

// File: rtl/sdram_fifo_arbiter.sv
// Round-robin burst scheduler between the camera write FIFO and the display
// read FIFO, with ping-pong frame banks above the SDRAM controller.
module sdram_fifo_arbiter #(
    parameter logic [8:0]  BURST_LEN   = 9'd256,
    parameter logic [22:0] FRAME_WORDS = 23'd307200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_level,
    input  logic [9:0]  rd_fifo_room,
    input  logic        wr_frame_sync,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    output logic [8:0]  sdram_wr_burst,
    output logic [8:0]  sdram_rd_burst,
    output logic [23:0] sdram_wr_addr,
    output logic [23:0] sdram_rd_addr,
    output logic        wr_frame_done,
    output logic        wr_bank,
    output logic        rd_bank
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } state_t;

    localparam logic [9:0]  BURST_CMP = {1'b0, BURST_LEN};
    localparam logic [22:0] BURST_INC = {14'd0, BURST_LEN};

    state_t      state;
    logic        wr_ok;
    logic        rd_ok;
    logic        wr_ack_q;
    logic        rd_ack_q;
    logic        last_rd;
    logic        sync_pend;
    logic        done_bank;
    logic [22:0] wr_offset;
    logic [22:0] rd_offset;
    logic [22:0] wr_next;
    logic [22:0] rd_next;
    logic        wr_done;
    logic        rd_done;

    assign wr_next = wr_offset + BURST_INC;
    assign rd_next = rd_offset + BURST_INC;

    // Burst complete is the falling edge of the controller acknowledge.
    assign wr_done = (state == WR_BUSY) && wr_ack_q && !sdram_wr_ack;
    assign rd_done = (state == RD_BUSY) && rd_ack_q && !sdram_rd_ack;

    assign sdram_wr_burst = BURST_LEN;
    assign sdram_rd_burst = BURST_LEN;
    assign sdram_wr_addr  = {wr_bank, wr_offset};
    assign sdram_rd_addr  = {rd_bank, rd_offset};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ok         <= 1'b0;
            rd_ok         <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            last_rd       <= 1'b1;
            sync_pend     <= 1'b0;
            done_bank     <= 1'b1;
            wr_offset     <= '0;
            rd_offset     <= '0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            wr_frame_done <= 1'b0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
        end else begin
            wr_ok         <= sdram_init_done && (wr_fifo_level >= BURST_CMP);
            rd_ok         <= sdram_init_done && (rd_fifo_room >= BURST_CMP);
            wr_ack_q      <= sdram_wr_ack;
            rd_ack_q      <= sdram_rd_ack;
            wr_frame_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (sdram_init_done && wr_ok && (!rd_ok || last_rd)) begin
                        state        <= WR_REQ;
                        sdram_wr_req <= 1'b1;
                        last_rd      <= 1'b0;
                    end else if (sdram_init_done && rd_ok) begin
                        state        <= RD_REQ;
                        sdram_rd_req <= 1'b1;
                        last_rd      <= 1'b1;
                    end
                end
                // Drop the request on the first ack so it is never re-accepted.
                WR_REQ: begin
                    if (sdram_wr_ack) begin
                        state        <= WR_BUSY;
                        sdram_wr_req <= 1'b0;
                    end
                end
                WR_BUSY: begin
                    if (wr_done) state <= IDLE;
                end
                RD_REQ: begin
                    if (sdram_rd_ack) begin
                        state        <= RD_BUSY;
                        sdram_rd_req <= 1'b0;
                    end
                end
                RD_BUSY: begin
                    if (rd_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A frame sync discards the partial frame without flipping banks.
            if (wr_done) begin
                sync_pend <= 1'b0;
                if (sync_pend || wr_frame_sync) begin
                    wr_offset <= '0;
                end else if (wr_next == FRAME_WORDS) begin
                    wr_offset     <= '0;
                    done_bank     <= wr_bank;
                    wr_bank       <= ~wr_bank;
                    wr_frame_done <= 1'b1;
                end else begin
                    wr_offset <= wr_next;
                end
            end else if (wr_frame_sync) begin
                if (state == WR_BUSY) sync_pend <= 1'b1;
                else                  wr_offset <= '0;
            end

            if (rd_done) begin
                if (rd_next == FRAME_WORDS) begin
                    rd_offset <= '0;
                    rd_bank   <= done_bank;
                end else begin
                    rd_offset <= rd_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_fifo_arbiter.sv
// Directed bench for sdram_fifo_arbiter: arbitration vector table plus
// sequences for ack handshake, frame sync, mid-burst reset and frame wrap.
module tb_sdram_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_room;
    logic        wr_frame_sync;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [8:0]  sdram_wr_burst;
    logic [8:0]  sdram_rd_burst;
    logic [23:0] sdram_wr_addr;
    logic [23:0] sdram_rd_addr;
    logic        wr_frame_done;
    logic        wr_bank;
    logic        rd_bank;

    sdram_fifo_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_room    (rd_fifo_room),
        .wr_frame_sync   (wr_frame_sync),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_burst  (sdram_rd_burst),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_rd_addr   (sdram_rd_addr),
        .wr_frame_done   (wr_frame_done),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Automatic controller model
    bit auto_ack = 0;
    int ack_delay = 1;
    int ack_len = 2;
    bit resp_busy = 0;
    bit fall_valid = 0;
    int fall_cyc = 0;

    always begin
        bit is_w;
        @(negedge clk);
        if (auto_ack && rst_n && (sdram_wr_req || sdram_rd_req)) begin
            is_w = sdram_wr_req;
            resp_busy = 1;
            for (int k = 0; k < ack_delay && auto_ack; k++) @(negedge clk);
            if (auto_ack) begin
                if (is_w) sdram_wr_ack = 1'b1;
                else      sdram_rd_ack = 1'b1;
                for (int k = 0; k < ack_len && auto_ack; k++) @(negedge clk);
            end
            sdram_wr_ack = 1'b0;
            sdram_rd_ack = 1'b0;
            if (auto_ack) begin
                fall_cyc = cyc;
                fall_valid = 1;
            end
            resp_busy = 0;
        end
    end

    // Grant monitor
    logic [24:0] glog[$];
    int wr_grants = 0;
    int rd_grants = 0;
    int fd_cnt = 0;
    int viol = 0;
    logic [23:0] last_wr_addr = '0;
    logic [23:0] last_rd_addr = '0;
    bit pw = 0;
    bit pr = 0;

    always begin
        @(posedge clk);
        #1;
        if (sdram_wr_req && !pw) begin
            wr_grants++;
            last_wr_addr = sdram_wr_addr;
            glog.push_back({1'b1, sdram_wr_addr});
            if (fall_valid) begin
                chk("burst_gap_wr", 32'(cyc - fall_cyc), 32'd2);
                fall_valid = 0;
            end
        end
        if (sdram_rd_req && !pr) begin
            rd_grants++;
            last_rd_addr = sdram_rd_addr;
            glog.push_back({1'b0, sdram_rd_addr});
            if (fall_valid) begin
                chk("burst_gap_rd", 32'(cyc - fall_cyc), 32'd2);
                fall_valid = 0;
            end
        end
        if ((sdram_wr_req && sdram_wr_ack) || (sdram_rd_req && sdram_rd_ack))
            viol++;
        if (wr_frame_done) fd_cnt++;
        pw = sdram_wr_req;
        pr = sdram_rd_req;
    end

    // Manual burst: ack for two cycles; sync_mode 1 = sync during busy,
    // 2 = sync on the completion cycle.
    task automatic do_burst(input bit is_wr, input int sync_mode);
        wr_fifo_level = '0;
        rd_fifo_room = '0;
        @(negedge clk);
        if (is_wr) sdram_wr_ack = 1'b1;
        else       sdram_rd_ack = 1'b1;
        @(negedge clk);
        chk("req_drop", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
        if (sync_mode == 1) wr_frame_sync = 1'b1;
        @(negedge clk);
        wr_frame_sync = 1'b0;
        if (sync_mode == 2) wr_frame_sync = 1'b1;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge clk);
        wr_frame_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic ask(input string nm, input logic [9:0] l,
                       input logic [9:0] r, input logic [1:0] ereq,
                       input logic [23:0] wa, input logic [23:0] ra);
        wr_fifo_level = l;
        rd_fifo_room = r;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_req"}, {30'd0, sdram_wr_req, sdram_rd_req}, {30'd0, ereq});
        chk({nm, "_wa"}, {8'd0, sdram_wr_addr}, {8'd0, wa});
        chk({nm, "_ra"}, {8'd0, sdram_rd_addr}, {8'd0, ra});
    endtask

    task automatic wait_quiet();
        int q = 0;
        int i = 0;
        while (q < 3 && i < 3000) begin
            @(negedge clk);
            i++;
            if (!resp_busy && !sdram_wr_req && !sdram_rd_req &&
                !sdram_wr_ack && !sdram_rd_ack) q++;
            else q = 0;
        end
        chk("quiet_timeout", {31'd0, q >= 3}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_wreq"}, {31'd0, sdram_wr_req}, 32'd0);
        chk({nm, "_rreq"}, {31'd0, sdram_rd_req}, 32'd0);
        chk({nm, "_wa"}, {8'd0, sdram_wr_addr}, 32'h000000);
        chk({nm, "_ra"}, {8'd0, sdram_rd_addr}, 32'h800000);
        chk({nm, "_wbank"}, {31'd0, wr_bank}, 32'd0);
        chk({nm, "_rbank"}, {31'd0, rd_bank}, 32'd1);
        chk({nm, "_fdone"}, {31'd0, wr_frame_done}, 32'd0);
    endtask

    typedef struct {
        logic        init;
        logic [9:0]  lvl;
        logic [9:0]  room;
        logic        ew;
        logic        er;
        logic [23:0] ewa;
        logic [23:0] era;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int fd0;
        int i;

        tbl[0] = '{1'b0, 10'd512,  10'd512,  1'b0, 1'b0, 24'h000000, 24'h800000};
        tbl[1] = '{1'b1, 10'd255,  10'd255,  1'b0, 1'b0, 24'h000000, 24'h800000};
        tbl[2] = '{1'b1, 10'd256,  10'd0,    1'b1, 1'b0, 24'h000000, 24'h800000};
        tbl[3] = '{1'b1, 10'd256,  10'd256,  1'b0, 1'b1, 24'h000100, 24'h800000};
        tbl[4] = '{1'b1, 10'd256,  10'd256,  1'b1, 1'b0, 24'h000100, 24'h800100};
        tbl[5] = '{1'b1, 10'd0,    10'd256,  1'b0, 1'b1, 24'h000200, 24'h800100};
        tbl[6] = '{1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0, 24'h000200, 24'h800200};
        tbl[7] = '{1'b1, 10'd1023, 10'd255,  1'b1, 1'b0, 24'h000300, 24'h800200};
        tbl[8] = '{1'b0, 10'd512,  10'd512,  1'b0, 1'b0, 24'h000400, 24'h800200};

        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_level = 10'd512;
        rd_fifo_room = 10'd512;
        wr_frame_sync = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        chk("burst_wr", {23'd0, sdram_wr_burst}, 32'd256);
        chk("burst_rd", {23'd0, sdram_rd_burst}, 32'd256);

        // Arbitration table
        foreach (tbl[v]) begin
            sdram_init_done = tbl[v].init;
            wr_fifo_level = tbl[v].lvl;
            rd_fifo_room = tbl[v].room;
            @(negedge clk);
            chk($sformatf("v%0d_lat1", v),
                {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_req", v), {30'd0, sdram_wr_req, sdram_rd_req},
                {30'd0, tbl[v].ew, tbl[v].er});
            chk($sformatf("v%0d_wa", v), {8'd0, sdram_wr_addr}, {8'd0, tbl[v].ewa});
            chk($sformatf("v%0d_ra", v), {8'd0, sdram_rd_addr}, {8'd0, tbl[v].era});
            if (tbl[v].ew) do_burst(1'b1, 0);
            else if (tbl[v].er) do_burst(1'b0, 0);
            else begin
                wr_fifo_level = '0;
                rd_fifo_room = '0;
                repeat (2) @(negedge clk);
            end
        end

        // Alternation with a long-ack controller; last grant was a write
        sdram_init_done = 1'b1;
        glog.delete();
        fall_valid = 0;
        ack_delay = 3;
        ack_len = 256;
        auto_ack = 1;
        wr_fifo_level = 10'd512;
        rd_fifo_room = 10'd512;
        i = 0;
        while (glog.size() < 4 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        wr_fifo_level = '0;
        rd_fifo_room = '0;
        chk("alt_count", glog.size(), 32'd4);
        wait_quiet();
        auto_ack = 0;
        fall_valid = 0;
        if (glog.size() >= 4) begin
            chk("alt_g0", {7'd0, glog[0]}, {7'd0, 1'b0, 24'h800200});
            chk("alt_g1", {7'd0, glog[1]}, {7'd0, 1'b1, 24'h000400});
            chk("alt_g2", {7'd0, glog[2]}, {7'd0, 1'b0, 24'h800300});
            chk("alt_g3", {7'd0, glog[3]}, {7'd0, 1'b1, 24'h000500});
        end

        // Reset in the middle of a read burst
        ack_delay = 1;
        ack_len = 20;
        auto_ack = 1;
        rd_fifo_room = 10'd512;
        i = 0;
        while (!sdram_rd_ack && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("rd_busy_reached", {31'd0, sdram_rd_ack}, 32'd1);
        repeat (3) @(negedge clk);
        chk("pre_rst_ra", {8'd0, sdram_rd_addr}, 32'h800400);
        #2;
        auto_ack = 0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        fall_valid = 0;
        rst_n = 1'b1;

        // Resume from offset 0, then frame-sync corners
        ask("resume0", 10'd512, 10'd0, 2'b10, 24'h000000, 24'h800000);
        do_burst(1'b1, 0);
        ask("resume1", 10'd512, 10'd0, 2'b10, 24'h000100, 24'h800000);
        do_burst(1'b1, 0);
        ask("resume2", 10'd512, 10'd0, 2'b10, 24'h000200, 24'h800000);
        fd0 = fd_cnt;
        do_burst(1'b1, 1);
        chk("sync_busy_wa", {8'd0, sdram_wr_addr}, 32'h000000);
        chk("sync_busy_bank", {31'd0, wr_bank}, 32'd0);
        chk("sync_busy_nofd", fd_cnt, fd0);
        ask("sync_cmp", 10'd512, 10'd0, 2'b10, 24'h000000, 24'h800000);
        do_burst(1'b1, 2);
        chk("sync_cmp_wa", {8'd0, sdram_wr_addr}, 32'h000000);
        ask("sync_idle", 10'd512, 10'd0, 2'b10, 24'h000000, 24'h800000);
        do_burst(1'b1, 0);
        chk("pre_sync_idle_wa", {8'd0, sdram_wr_addr}, 32'h000100);
        wr_frame_sync = 1'b1;
        @(negedge clk);
        wr_frame_sync = 1'b0;
        chk("sync_idle_wa", {8'd0, sdram_wr_addr}, 32'h000000);

        // Full-frame write, then read wrap onto the finished bank
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_grants = 0;
        rd_grants = 0;
        fd0 = fd_cnt;
        fall_valid = 0;
        ack_delay = 1;
        ack_len = 2;
        auto_ack = 1;
        wr_fifo_level = 10'd512;
        rd_fifo_room = 10'd0;
        i = 0;
        while (fd_cnt == fd0 && i < 20000) begin
            @(negedge clk);
            i++;
        end
        chk("frame_done_seen", {31'd0, fd_cnt != fd0}, 32'd1);
        chk("frame_wr_grants", wr_grants, 32'd1200);
        chk("frame_last_wa", {8'd0, last_wr_addr}, 32'h04AF00);
        chk("frame_wbank", {31'd0, wr_bank}, 32'd1);
        chk("frame_wa_wrap", {8'd0, sdram_wr_addr}, 32'h800000);
        chk("frame_rbank_hold", {31'd0, rd_bank}, 32'd1);
        wr_fifo_level = '0;
        wait_quiet();
        fall_valid = 0;
        chk("frame_done_once", fd_cnt, fd0 + 1);
        rd_fifo_room = 10'd512;
        i = 0;
        while (rd_bank != 1'b0 && i < 20000) begin
            @(negedge clk);
            i++;
        end
        chk("rd_wrap_bank", {31'd0, rd_bank}, 32'd0);
        chk("rd_wrap_grants", rd_grants, 32'd1200);
        chk("rd_last_ra", {8'd0, last_rd_addr}, 32'h84AF00);
        chk("rd_wrap_ra", {8'd0, sdram_rd_addr}, 32'h000000);
        rd_fifo_room = '0;
        wait_quiet();
        auto_ack = 0;
        chk("req_during_ack", viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
